// File: rtl/pipe_fwd_if.sv
// Bundle between decode and the forwarding controller.
// master: decode side (drives issue info, sources, stage results, rf data).
// slave : pipe_fwd_ctrl (returns resolved operands, selects, stall, counter).
interface pipe_fwd_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SEL_W  = 2
);
  logic                    hold_i;
  logic                    flush_i;
  logic                    issue_valid_i;
  logic                    issue_wr_i;
  logic                    issue_load_i;
  logic [REG_AW-1:0]       issue_rd_i;
  logic [REG_AW-1:0]       rs_i;
  logic [REG_AW-1:0]       rt_i;
  logic                    rs_used_i;
  logic                    rt_used_i;
  logic [DEPTH*DATA_W-1:0] stage_data_i;
  logic [DATA_W-1:0]       rf_rs_data_i;
  logic [DATA_W-1:0]       rf_rt_data_i;
  logic [DATA_W-1:0]       rs_data_o;
  logic [DATA_W-1:0]       rt_data_o;
  logic [SEL_W-1:0]        rs_sel_o;
  logic [SEL_W-1:0]        rt_sel_o;
  logic                    load_stall_o;
  logic [15:0]             stall_cnt_o;

  modport master (
    output hold_i, flush_i, issue_valid_i, issue_wr_i, issue_load_i, issue_rd_i,
           rs_i, rt_i, rs_used_i, rt_used_i, stage_data_i, rf_rs_data_i, rf_rt_data_i,
    input  rs_data_o, rt_data_o, rs_sel_o, rt_sel_o, load_stall_o, stall_cnt_o
  );

  modport slave (
    input  hold_i, flush_i, issue_valid_i, issue_wr_i, issue_load_i, issue_rd_i,
           rs_i, rt_i, rs_used_i, rt_used_i, stage_data_i, rf_rs_data_i, rf_rt_data_i,
    output rs_data_o, rt_data_o, rs_sel_o, rt_sel_o, load_stall_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_fwd_ctrl.sv
// Hazard/forwarding controller for the in-order WISC pipeline.
// Tracks DEPTH in-flight producers (stage 1 = EX out ... stage DEPTH = WB),
// resolves rs/rt against the youngest matching producer, forwards its result
// word, and raises a load-use stall when the load's data is not yet valid.
// Ports: clk, rst (async, active-high), bus (pipe_fwd_if.slave).
// Resolved data, selects and load_stall_o are combinational (zero latency);
// stall_cnt_o is registered and saturates at 16'hFFFF.
// Optional: define ZERO_REG_EN to hardwire register 0 to zero.
// Legal configs: 1 <= DEPTH <= 7, 1 <= LOAD_STAGE <= DEPTH, 2**SEL_W > DEPTH.
module pipe_fwd_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic       clk,
  input  logic       rst,
  pipe_fwd_if.slave  bus
);

  logic [DEPTH:1]    vld;
  logic [DEPTH:1]    wr;
  logic [DEPTH:1]    ld;
  logic [REG_AW-1:0] rd [DEPTH:1];
  logic [15:0]       stall_cnt;

  logic              rs_zero;
  logic              rt_zero;
  logic              issue_wr;
  logic [SEL_W-1:0]  rs_sel;
  logic [SEL_W-1:0]  rt_sel;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_hz;
  logic              rt_hz;
  logic              load_stall;

  // Register 0 handling: a zero source never matches and a write to r0 is dropped.
`ifdef ZERO_REG_EN
  assign rs_zero  = (bus.rs_i == '0);
  assign rt_zero  = (bus.rt_i == '0);
  assign issue_wr = bus.issue_wr_i & (bus.issue_rd_i != '0);
`else
  assign rs_zero  = 1'b0;
  assign rt_zero  = 1'b0;
  assign issue_wr = bus.issue_wr_i;
`endif

  // Priority resolve: walk oldest to youngest so the youngest match wins.
  always_comb begin
    rs_sel  = '0;
    rs_data = bus.rf_rs_data_i;
    rs_hz   = 1'b0;
    rt_sel  = '0;
    rt_data = bus.rf_rt_data_i;
    rt_hz   = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld[k] && wr[k] && bus.rs_used_i && !rs_zero && (rd[k] == bus.rs_i)) begin
        rs_sel  = SEL_W'(k);
        rs_data = bus.stage_data_i[k*DATA_W-1 -: DATA_W];
        rs_hz   = ld[k] && (k < int'(LOAD_STAGE));
      end
      if (vld[k] && wr[k] && bus.rt_used_i && !rt_zero && (rd[k] == bus.rt_i)) begin
        rt_sel  = SEL_W'(k);
        rt_data = bus.stage_data_i[k*DATA_W-1 -: DATA_W];
        rt_hz   = ld[k] && (k < int'(LOAD_STAGE));
      end
    end
    if (rs_zero) rs_data = '0;
    if (rt_zero) rt_data = '0;
  end

  assign load_stall = rs_hz | rt_hz;

  // Tag pipeline and stall counter; hold freezes everything including flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      wr        <= '0;
      ld        <= '0;
      stall_cnt <= '0;
      for (int k = 1; k <= DEPTH; k++) rd[k] <= '0;
    end else if (!bus.hold_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        vld[k] <= vld[k-1];
        wr[k]  <= wr[k-1];
        ld[k]  <= ld[k-1];
        rd[k]  <= rd[k-1];
      end
      vld[1] <= bus.issue_valid_i & ~bus.flush_i & ~load_stall;
      wr[1]  <= issue_wr;
      ld[1]  <= bus.issue_load_i;
      rd[1]  <= bus.issue_rd_i;
      if (load_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.rs_sel_o     = rs_sel;
  assign bus.rt_sel_o     = rt_sel;
  assign bus.rs_data_o    = rs_data;
  assign bus.rt_data_o    = rt_data;
  assign bus.load_stall_o = load_stall;
  assign bus.stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Self-checking bench for pipe_fwd_ctrl: directed scenarios plus randomized
// traffic against a history-queue reference model.
module tb_pipe_fwd_ctrl;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_AW     = 3;
  localparam int unsigned DEPTH      = 3;
  localparam int unsigned LOAD_STAGE = 2;
  localparam int unsigned SEL_W      = 2;

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // hist[0] is the most recently accepted issue slot (bubble or instruction).
  ent_t              hist[$];
  logic [SEL_W-1:0]  exp_rs_sel, exp_rt_sel;
  logic [DATA_W-1:0] exp_rs_data, exp_rt_data;
  logic              exp_stall;
  logic [15:0]       exp_cnt;

  pipe_fwd_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) bus ();

  pipe_fwd_ctrl #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
    .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    ent_t b;
    b = '0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(b);
    exp_cnt = '0;
  endfunction

  // Expected outputs from the producer history: first (youngest) writer of src.
  function automatic void model_eval();
    logic rs_found, rt_found, rs_z, rt_z;
    rs_found = 1'b0; rt_found = 1'b0; exp_stall = 1'b0;
    exp_rs_sel = '0; exp_rt_sel = '0;
    exp_rs_data = bus.rf_rs_data_i; exp_rt_data = bus.rf_rt_data_i;
    rs_z = 1'b0; rt_z = 1'b0;
`ifdef ZERO_REG_EN
    rs_z = (bus.rs_i == 0);
    rt_z = (bus.rt_i == 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (!rs_found && !rs_z && bus.rs_used_i && hist[i].vld && hist[i].wr && hist[i].rd == bus.rs_i) begin
        rs_found = 1'b1;
        exp_rs_sel = SEL_W'(i + 1);
        exp_rs_data = bus.stage_data_i[(i+1)*DATA_W-1 -: DATA_W];
        if (hist[i].ld && (i + 1) < LOAD_STAGE) exp_stall = 1'b1;
      end
      if (!rt_found && !rt_z && bus.rt_used_i && hist[i].vld && hist[i].wr && hist[i].rd == bus.rt_i) begin
        rt_found = 1'b1;
        exp_rt_sel = SEL_W'(i + 1);
        exp_rt_data = bus.stage_data_i[(i+1)*DATA_W-1 -: DATA_W];
        if (hist[i].ld && (i + 1) < LOAD_STAGE) exp_stall = 1'b1;
      end
    end
    if (rs_z) exp_rs_data = '0;
    if (rt_z) exp_rt_data = '0;
  endfunction

  // One clock edge: DUT and model both advance unless held.
  task automatic tick();
    ent_t e;
    model_eval();
    @(posedge clk);
    if (!bus.hold_i) begin
      if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt++;
      e.vld = bus.issue_valid_i && !bus.flush_i && !exp_stall;
      e.wr  = bus.issue_wr_i;
`ifdef ZERO_REG_EN
      if (bus.issue_rd_i == 0) e.wr = 1'b0;
`endif
      e.ld  = bus.issue_load_i;
      e.rd  = bus.issue_rd_i;
      void'(hist.pop_back());
      hist.push_front(e);
    end
    #1;
  endtask

  task automatic idle();
    bus.hold_i = 1'b0; bus.flush_i = 1'b0;
    bus.issue_valid_i = 1'b0; bus.issue_wr_i = 1'b0; bus.issue_load_i = 1'b0; bus.issue_rd_i = '0;
    bus.rs_i = '0; bus.rt_i = '0; bus.rs_used_i = 1'b0; bus.rt_used_i = 1'b0;
    bus.stage_data_i = 48'({$urandom(), $urandom()});
    bus.rf_rs_data_i = DATA_W'($urandom()); bus.rf_rt_data_i = DATA_W'($urandom());
  endtask

  task automatic issue(input logic w, input logic l, input logic [REG_AW-1:0] r);
    bus.issue_valid_i = 1'b1; bus.issue_wr_i = w; bus.issue_load_i = l; bus.issue_rd_i = r;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.rs_i = 3'd3; bus.rs_used_i = 1'b1; bus.rf_rs_data_i = 16'h1111;
    #1;
    checks++; if (bus.rs_sel_o !== 2'd0) begin errors++; $display("FAIL reset_rs_sel: got %0d expected 0", bus.rs_sel_o); end
    checks++; if (bus.rs_data_o !== 16'h1111) begin errors++; $display("FAIL reset_rs_data: got %h expected 1111", bus.rs_data_o); end
    checks++; if (bus.load_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.load_stall_o); end
    checks++; if (bus.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt_o); end
    // Load a producer of r3, then reset asynchronously mid-cycle.
    issue(1'b1, 1'b1, 3'd3);
    tick();
    bus.issue_valid_i = 1'b0;
    #1;
    checks++; if (bus.rs_sel_o !== 2'd1) begin errors++; $display("FAIL prereset_sel: got %0d expected 1", bus.rs_sel_o); end
    checks++; if (bus.load_stall_o !== 1'b1) begin errors++; $display("FAIL prereset_stall: got %b expected 1", bus.load_stall_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.rs_sel_o !== 2'd0 || bus.rs_data_o !== 16'h1111 || bus.load_stall_o !== 1'b0)
      begin errors++; $display("FAIL async_reset: got sel %0d data %h stall %b expected 0 1111 0", bus.rs_sel_o, bus.rs_data_o, bus.load_stall_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_forward();
    logic [SEL_W-1:0] want_sel;
    logic [DATA_W-1:0] want_data;
    do_reset();
    issue(1'b1, 1'b0, 3'd2);
    tick();
    bus.issue_valid_i = 1'b0;
    bus.rs_i = 3'd2; bus.rs_used_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.stage_data_i = 48'({$urandom(), $urandom()});
      if (j == 0) bus.stage_data_i[15:0] = 16'hABCD;
      #1;
      want_sel  = (j < 3) ? SEL_W'(j + 1) : '0;
      want_data = (j < 3) ? bus.stage_data_i[(j+1)*DATA_W-1 -: DATA_W] : bus.rf_rs_data_i;
      if (j == 0) want_data = 16'hABCD;
      checks++; if (bus.rs_sel_o !== want_sel) begin errors++; $display("FAIL fwd_sel_%0d: got %0d expected %0d", j, bus.rs_sel_o, want_sel); end
      checks++; if (bus.rs_data_o !== want_data) begin errors++; $display("FAIL fwd_data_%0d: got %h expected %h", j, bus.rs_data_o, want_data); end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(1'b1, 1'b1, 3'd5);
    tick();
    issue(1'b1, 1'b0, 3'd1);
    bus.rt_i = 3'd5; bus.rt_used_i = 1'b1;
    #1;
    checks++; if (bus.load_stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", bus.load_stall_o); end
    checks++; if (bus.rt_sel_o !== 2'd1) begin errors++; $display("FAIL lu_sel1: got %0d expected 1", bus.rt_sel_o); end
    tick();
    #1;
    checks++; if (bus.load_stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_drop: got %b expected 0", bus.load_stall_o); end
    checks++; if (bus.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", bus.stall_cnt_o); end
    checks++; if (bus.rt_sel_o !== 2'd2) begin errors++; $display("FAIL lu_sel2: got %0d expected 2", bus.rt_sel_o); end
    checks++; if (bus.rt_data_o !== bus.stage_data_i[31:16]) begin errors++; $display("FAIL lu_data: got %h expected %h", bus.rt_data_o, bus.stage_data_i[31:16]); end
    tick();
    bus.issue_valid_i = 1'b0;
    bus.rt_i = 3'd1;
    #1;
    // The instruction stalled earlier must have entered once, behind the bubble.
    checks++; if (bus.rt_sel_o !== 2'd1) begin errors++; $display("FAIL lu_retry_sel: got %0d expected 1", bus.rt_sel_o); end
  endtask

  task automatic test_hold();
    do_reset();
    issue(1'b1, 1'b1, 3'd5);
    tick();
    issue(1'b1, 1'b0, 3'd6);
    bus.rt_i = 3'd5; bus.rt_used_i = 1'b1; bus.hold_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (bus.load_stall_o !== 1'b1 || bus.rt_sel_o !== 2'd1 || bus.stall_cnt_o !== 16'd0)
        begin errors++; $display("FAIL hold_%0d: got stall %b sel %0d cnt %0d expected 1 1 0", j, bus.load_stall_o, bus.rt_sel_o, bus.stall_cnt_o); end
      tick();
    end
    bus.hold_i = 1'b0;
    tick();
    #1;
    checks++; if (bus.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL hold_cnt: got %0d expected 1", bus.stall_cnt_o); end
    checks++; if (bus.load_stall_o !== 1'b0 || bus.rt_sel_o !== 2'd2)
      begin errors++; $display("FAIL hold_release: got stall %b sel %0d expected 0 2", bus.load_stall_o, bus.rt_sel_o); end
  endtask

  task automatic test_youngest_flush();
    do_reset();
    issue(1'b1, 1'b0, 3'd4); tick();
    issue(1'b1, 1'b0, 3'd1); tick();
    issue(1'b1, 1'b0, 3'd4); tick();
    bus.issue_valid_i = 1'b0;
    bus.stage_data_i = {16'h3333, 16'h2222, 16'h1111};
    bus.rs_i = 3'd4; bus.rs_used_i = 1'b1;
    #1;
    checks++; if (bus.rs_sel_o !== 2'd1 || bus.rs_data_o !== 16'h1111)
      begin errors++; $display("FAIL youngest: got sel %0d data %h expected 1 1111", bus.rs_sel_o, bus.rs_data_o); end
    issue(1'b1, 1'b0, 3'd6);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.issue_valid_i = 1'b0;
    bus.rs_i = 3'd6;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (bus.rs_sel_o !== 2'd0 || bus.rs_data_o !== bus.rf_rs_data_i)
        begin errors++; $display("FAIL flush_%0d: got sel %0d data %h expected 0 %h", j, bus.rs_sel_o, bus.rs_data_o, bus.rf_rs_data_i); end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    logic [SEL_W-1:0] want_sel;
    logic [DATA_W-1:0] want_data;
    do_reset();
    issue(1'b1, 1'b0, 3'd0);
    tick();
    bus.issue_valid_i = 1'b0;
    bus.rs_i = 3'd0; bus.rs_used_i = 1'b1; bus.rf_rs_data_i = 16'h1234;
    bus.stage_data_i[15:0] = 16'h5A5A;
    #1;
`ifdef ZERO_REG_EN
    want_sel = 2'd0; want_data = 16'h0000;
`else
    want_sel = 2'd1; want_data = 16'h5A5A;
`endif
    checks++; if (bus.rs_sel_o !== want_sel || bus.rs_data_o !== want_data)
      begin errors++; $display("FAIL zero_reg: got sel %0d data %h expected %0d %h", bus.rs_sel_o, bus.rs_data_o, want_sel, want_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.hold_i = ($urandom_range(0, 9) < 2);
      bus.flush_i = ($urandom_range(0, 9) == 0);
      bus.issue_valid_i = ($urandom_range(0, 9) < 8);
      bus.issue_wr_i = ($urandom_range(0, 9) < 8);
      bus.issue_load_i = ($urandom_range(0, 9) < 4);
      bus.issue_rd_i = REG_AW'($urandom());
      bus.rs_i = REG_AW'($urandom()); bus.rt_i = REG_AW'($urandom());
      bus.rs_used_i = ($urandom_range(0, 9) < 8); bus.rt_used_i = ($urandom_range(0, 9) < 7);
      bus.stage_data_i = 48'({$urandom(), $urandom()});
      bus.rf_rs_data_i = DATA_W'($urandom()); bus.rf_rt_data_i = DATA_W'($urandom());
      #1;
      model_eval();
      checks++; if (bus.rs_sel_o !== exp_rs_sel || bus.rs_data_o !== exp_rs_data)
        begin errors++; $display("FAIL rnd_rs_%0d: got sel %0d data %h expected %0d %h", n, bus.rs_sel_o, bus.rs_data_o, exp_rs_sel, exp_rs_data); end
      checks++; if (bus.rt_sel_o !== exp_rt_sel || bus.rt_data_o !== exp_rt_data)
        begin errors++; $display("FAIL rnd_rt_%0d: got sel %0d data %h expected %0d %h", n, bus.rt_sel_o, bus.rt_data_o, exp_rt_sel, exp_rt_data); end
      checks++; if (bus.load_stall_o !== exp_stall)
        begin errors++; $display("FAIL rnd_stall_%0d: got %b expected %b", n, bus.load_stall_o, exp_stall); end
      checks++; if (bus.stall_cnt_o !== exp_cnt)
        begin errors++; $display("FAIL rnd_cnt_%0d: got %0d expected %0d", n, bus.stall_cnt_o, exp_cnt); end
      tick();
    end
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_forward();
    test_load_use();
    test_hold();
    test_youngest_flush();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
